// File: rtl/qp_delta_debin.sv
// Serial debinarizer for cu_qp_delta_abs: TU prefix (cMax = CMAX) followed by an EG0 suffix.
// Define QP_DELTA_DEBIN_SIGN_EN to also consume the sign bin and drive signed cu_qp_delta.
module qp_delta_debin #(
   parameter int VALUE_WIDTH   = 16,
   parameter int BIN_WIDTH     = 16,
   parameter int CMAX          = 5,
   parameter int MAX_EG_PREFIX = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   bin_valid,
   input  logic                   bin_i,
   output logic                   bin_ready,
   output logic                   done,
   output logic                   error,
   output logic [VALUE_WIDTH-1:0] cu_qp_delta_abs,
   output logic [BIN_WIDTH-1:0]   bin_length
`ifdef QP_DELTA_DEBIN_SIGN_EN
   ,
   output logic signed [VALUE_WIDTH:0] cu_qp_delta
`endif
);

   localparam int PW = $clog2(CMAX + 1);
   localparam int KW = $clog2(VALUE_WIDTH + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PREFIX = 3'd1;
   localparam logic [2:0] S_EG_PRE = 3'd2;
   localparam logic [2:0] S_EG_SUF = 3'd3;
   localparam logic [2:0] S_FIN    = 3'd4;
`ifdef QP_DELTA_DEBIN_SIGN_EN
   localparam logic [2:0] S_SIGN    = 3'd5;
   localparam logic [2:0] S_NZ_DONE = S_SIGN;
`else
   localparam logic [2:0] S_NZ_DONE = S_FIN;
`endif

   localparam logic [PW-1:0]          PCNT_LAST = PW'(CMAX - 1);
   localparam logic [KW-1:0]          K_LIMIT   = KW'(MAX_EG_PREFIX);
   localparam logic [VALUE_WIDTH-1:0] BASE0     = VALUE_WIDTH'(CMAX);

   logic [2:0]             state;
   logic [PW-1:0]          pcnt;
   logic [KW-1:0]          k;
   logic [KW-1:0]          rem;
   logic [VALUE_WIDTH-1:0] base;
   logic [VALUE_WIDTH-1:0] value;
   logic [VALUE_WIDTH-1:0] value_sfx;
   logic                   err;
   logic                   accept;
`ifdef QP_DELTA_DEBIN_SIGN_EN
   logic                   sign;
`endif

   always_comb begin
      bin_ready = (state == S_PREFIX) || (state == S_EG_PRE) || (state == S_EG_SUF);
`ifdef QP_DELTA_DEBIN_SIGN_EN
      bin_ready = bin_ready || (state == S_SIGN);
`endif
   end

   assign accept          = bin_valid && bin_ready && !start;
   assign done            = (state == S_FIN);
   assign error           = err;
   assign cu_qp_delta_abs = value;
   // The suffix is added into value bit by bit (weight 2^(rem-1)), so base + sfx needs no separate shifter.
   assign value_sfx = value + (VALUE_WIDTH'(bin_i) << (rem - 1'b1));

`ifdef QP_DELTA_DEBIN_SIGN_EN
   assign cu_qp_delta = sign ? -$signed({1'b0, value}) : $signed({1'b0, value});
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pcnt       <= '0;
         k          <= '0;
         rem        <= '0;
         base       <= '0;
         value      <= '0;
         err        <= 1'b0;
         bin_length <= '0;
`ifdef QP_DELTA_DEBIN_SIGN_EN
         sign       <= 1'b0;
`endif
      end else if (start) begin
         state      <= S_PREFIX;
         pcnt       <= '0;
         k          <= '0;
         rem        <= '0;
         base       <= '0;
         value      <= '0;
         err        <= 1'b0;
         bin_length <= '0;
`ifdef QP_DELTA_DEBIN_SIGN_EN
         sign       <= 1'b0;
`endif
      end else begin
         if (accept && (bin_length != '1))
            bin_length <= bin_length + 1'b1;
         case (state)
            S_PREFIX: if (accept) begin
               if (!bin_i) begin
                  value <= VALUE_WIDTH'(pcnt);
                  state <= (pcnt != '0) ? S_NZ_DONE : S_FIN;
               end else if (pcnt == PCNT_LAST) begin
                  base  <= BASE0;
                  k     <= '0;
                  state <= S_EG_PRE;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            S_EG_PRE: if (accept) begin
               if (bin_i) begin
                  if (k == K_LIMIT) begin
                     err   <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     base <= base + (VALUE_WIDTH'(1) << k);
                     k    <= k + 1'b1;
                  end
               end else if (k != '0) begin
                  value <= base;
                  rem   <= k;
                  state <= S_EG_SUF;
               end else begin
                  value <= base;
                  state <= (base != '0) ? S_NZ_DONE : S_FIN;
               end
            end
            S_EG_SUF: if (accept) begin
               value <= value_sfx;
               rem   <= rem - 1'b1;
               if (rem == KW'(1))
                  state <= (value_sfx != '0) ? S_NZ_DONE : S_FIN;
            end
`ifdef QP_DELTA_DEBIN_SIGN_EN
            S_SIGN: if (accept) begin
               sign  <= bin_i;
               state <= S_FIN;
            end
`endif
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/qp_delta_debin.md
# qp_delta_debin

Serial debinarizer for the HEVC `cu_qp_delta_abs` syntax element: the decoder-side inverse of our QP delta binarizer. It consumes one bin per accepted cycle, most-significant bin first, from the arithmetic-decoder bin stream. It parses the truncated-unary prefix (cMax = 5, K = 0), then, when the prefix saturates, a 0th-order Exp-Golomb suffix. It outputs the reconstructed absolute value and the number of bins consumed. It sits between the CABAC bin decoder and the QP derivation logic.

## Interface
- `VALUE_WIDTH`, 16: width of the reconstructed value.
- `BIN_WIDTH`, 16: width of the bin counter output.
- `CMAX`, 5: truncated-unary prefix maximum.
- `MAX_EG_PREFIX`, 15: maximum number of Exp-Golomb unary ones before a parse error is raised.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a new parse and aborts any parse in progress.
- `bin_valid`  in  1  `bin_i` is valid.
- `bin_i`  in  1  the next bin.
- `bin_ready`  out  1  high in states PREFIX, EG_PRE and EG_SUF (plus SIGN when configured).
- `done`  out  1  one-cycle pulse when the result is final.
- `error`  out  1  qualified by `done`; the Exp-Golomb prefix exceeded `MAX_EG_PREFIX`.
- `cu_qp_delta_abs`  out  VALUE_WIDTH  decoded value; held from `done` until the next `start`.
- `bin_length`  out  BIN_WIDTH  number of bins accepted for this element.

## Operation
- A bin is accepted only in a cycle where `bin_valid && bin_ready`. All other cycles hold state.
- States are IDLE, PREFIX, EG_PRE, EG_SUF, FIN. SIGN is added only when configured.
- IDLE: `bin_ready` = 0. On `start`: clear the counters and accumulators, then go to PREFIX.
- PREFIX: count ones in `pcnt`.
  - A 0 bin sets value = `pcnt` and goes to FIN.
  - The 5th consecutive 1 (`pcnt` reaches CMAX) goes to EG_PRE with no terminator bin consumed. Set k = 0 and base = CMAX.
- EG_PRE: on each 1 bin, base += (1 << k), then k += 1.
  - If k would exceed `MAX_EG_PREFIX`, set `error` and go to FIN.
  - A 0 bin goes to EG_SUF if k > 0, otherwise to FIN with value = base.
- EG_SUF: shift k bins MSB-first into `sfx`. After the k-th bin, value = base + `sfx`, then go to FIN.
- FIN: pulse `done` for one cycle, latch the outputs, return to IDLE.
- `bin_length` increments on every accepted bin, saturating at all-ones.
- Arithmetic is unsigned at VALUE_WIDTH; overflow wraps. `MAX_EG_PREFIX` must be less than VALUE_WIDTH.

## Timing
- Reset values: `bin_ready` = 0, `done` = 0, `error` = 0, `cu_qp_delta_abs` = 0, `bin_length` = 0, state = IDLE.
- `bin_ready` rises the cycle after `start`.
- `done` rises the cycle after the last bin is accepted. Total latency = accepted bins + 2 cycles from `start`, counted with no stalls.
- `start` in any state restarts the parse: state goes to PREFIX and all counters clear on that edge. Any bin presented in the same cycle as `start` is ignored.
- `rst_n` asserted mid-parse: immediate return to reset values, no `done`.
- Deasserting `bin_valid` stalls without loss of state in every state.

## Configuration
- `QP_DELTA_DEBIN_SIGN_EN` defined:
  - After a nonzero absolute value, state SIGN consumes one bin (`cu_qp_delta_sign_flag`).
  - An extra output `cu_qp_delta` (signed, VALUE_WIDTH+1) = ±abs, where a sign bin of 1 means negative.
  - `bin_length` includes the sign bin.
  - abs = 0 skips SIGN.
- Not defined: no SIGN state, no `cu_qp_delta` port. Behaviour is exactly as above.

## Test plan
- Bins "0" → `done`, abs = 0, `bin_length` = 1, `error` = 0.
- Bins "1110" → abs = 3, `bin_length` = 4.
- Bins "111110" → abs = 5, `bin_length` = 6. Bins "11111101" → abs = 7, `bin_length` = 8. Bins "1111111000" → abs = 8, `bin_length` = 10.
- Bins "11111101" with `bin_valid` low for 3 cycles after bins 2 and 6 → abs = 7, `bin_length` = 8, `done` exactly once.
- `start` reissued after 3 bins of "1111", then "10" → abs = 1, `bin_length` = 2. Separately, `rst_n` pulsed mid-parse → all outputs 0, no `done`.
- Bins "11111" followed by 16 ones with `MAX_EG_PREFIX` = 15 → `done` with `error` = 1. With `QP_DELTA_DEBIN_SIGN_EN`: "1101" → abs = 2, `cu_qp_delta` = −2, `bin_length` = 4.
